// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage (MIPS DIV/DIVU).
// Returns {remainder, quotient} and requests a pipeline stall while busy.
module ex_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic               dvd_neg;
  logic               dvs_neg;
  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;

  // One restoring step; the dividend register doubles as the quotient shifter
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[WIDTH];
    rem_step = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {dvd_q[WIDTH-2:0], fits};
    quo_fix  = q_neg_q ? (WIDTH'(0) - quo_step) : quo_step;
    rem_fix  = r_neg_q ? (WIDTH'(0) - rem_step) : rem_step;
    dvd_neg  = signed_i & dividend_i[WIDTH-1];
    dvs_neg  = signed_i & divisor_i[WIDTH-1];
    dvd_abs  = dvd_neg ? (WIDTH'(0) - dividend_i) : dividend_i;
    dvs_abs  = dvs_neg ? (WIDTH'(0) - divisor_i) : divisor_i;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (divisor_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            dvd_d   = dvd_abs;
            dvs_d   = dvs_abs;
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          dvd_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = S_END;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Stall is combinational so the request lands in the same cycle start_i rises
  assign stallreq_o = ~rst & (((state_q == S_FREE) & start_i & ~annul_i) |
                              (state_q == S_ON) | (state_q == S_BYZERO));
  assign result_o   = result_q;
  assign ready_o    = ready_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized scoreboard bench for ex_div_unit against an arithmetic reference model.
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        ready_prev;

  ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: MIPS semantics via native truncating division on 64-bit integers
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every new result presented is popped from the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      ready_prev = 1'b0;
    end else begin
      if (ready_o && !ready_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {63'd0, ready_o}, 64'd0);
        end else begin
          check("result", result_o, exp_q.pop_front());
        end
      end
      ready_prev = ready_o;
    end
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int          cyc;
    int          stalls;
    int          hold;
    bit          seen;
    logic [63:0] e;
    e = model(a, b, s);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
    cyc = 0; stalls = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ready_o) seen = 1;
      else if (stallreq_o) stalls++;
      if (cyc == 2) begin
        dividend_i = $urandom; divisor_i = $urandom; signed_i = 1'($urandom);
      end
    end
    check("ready_seen", {63'd0, seen}, 64'd1);
    check("stall_cycles", 64'(stalls), (b == 32'd0) ? 64'd2 : 64'd33);
    check("stall_in_end", {63'd0, stallreq_o}, 64'd0);
    hold = int'($urandom_range(0, 2));
    repeat (hold) begin
      @(negedge clk);
      check("end_hold_ready", {63'd0, ready_o}, 64'd1);
      check("end_hold_result", result_o, e);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("end_last_ready", {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    check("free_ready", {63'd0, ready_o}, 64'd0);
    check("free_result", result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit          got_ready;
    logic [31:0] a, b;
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0;
    dividend_i = 32'd0; divisor_i = 32'd0; ready_prev = 1'b0;
    #1;
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_stall", {63'd0, stallreq_o}, 64'd0);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_div(32'd100, 32'd7, 1'b0);
    do_div(32'hFFFFFFF9, 32'h2, 1'b1);
    do_div(32'd7, 32'hFFFFFFFE, 1'b1);
    do_div(32'd123, 32'd0, 1'b1);
    do_div(32'd123, 32'd0, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b0);

    // Annul at iteration 10 discards the divide
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    @(negedge clk);
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_stall", {63'd0, stallreq_o}, 64'd0);
    got_ready = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) got_ready = 1;
    end
    check("annul_no_ready", {63'd0, got_ready}, 64'd0);
    do_div(32'd9, 32'd3, 1'b0);

    // Asynchronous reset mid-divide
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b1; dividend_i = $urandom; divisor_i = 32'd5;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check("async_rst_result", result_o, 64'd0);
    check("async_rst_stall", {63'd0, stallreq_o}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div(32'd1000, 32'd33, 1'b0);

    for (int i = 0; i < 50; i++) begin
      case ($urandom % 8)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      case ($urandom % 6)
        0:       a = 32'h80000000;
        1:       a = $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      do_div(a, b, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
